// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID register.
//
// Owns the program counter, issues word fetches on a req/ready memory port
// (wait states allowed, zero-wait supported), buffers up to two fetched
// words, predecodes branch/jump opcodes on the buffer head and drives a
// bubble/flush strobe towards IF/ID.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   stall                 IF/ID not accepting this cycle
//   redirect_valid/_pc    flush and refetch from redirect_pc (low 2 bits ignored)
//   imem_req/addr         memory request, held stable until imem_ready
//   imem_ready/rdata      memory response; transfer = imem_req & imem_ready
//   PC, inCode            head entry fetch address + 4 and instruction (0 when empty)
//   branch, jump, BEQ, BNE  predecode flags of head (0 when empty)
//   fetch_valid           buffer non-empty
//   stall_branch          bubble/flush strobe to IF/ID
//
// Optional feature: define FETCH_JUMP_SHORTCUT_EN to redirect the fetch PC
// directly to the target of a fetched J/JAL instead of pc+4.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] inCode,
    output logic        branch,
    output logic        jump,
    output logic        BEQ,
    output logic        BNE,
    output logic        fetch_valid,
    output logic        stall_branch
);

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_reg, pc_nxt;
    logic [31:0] drain_addr, drain_addr_nxt;
    // Holds the request low for one cycle after reset so memory sees a clean idle.
    logic        req_en;
    logic [31:0] buf_pc   [2];
    logic [31:0] buf_inst [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;
    logic        push, pop;
    logic [31:0] pc_plus4, redirect_aligned;
    logic [5:0]  op;

    assign pc_plus4         = pc_reg + 32'd4;
    assign redirect_aligned = redirect_pc & ~32'h0000_0003;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc_reg;
        drain_addr_nxt = drain_addr;
        imem_req       = 1'b0;
        imem_addr      = pc_reg;
        push           = 1'b0;
        case (state)
            FETCH: begin
                imem_req  = req_en & (count < 2'd2);
                imem_addr = pc_reg;
                if (redirect_valid) begin
                    pc_nxt = redirect_aligned;
                    // A request already on the bus must complete before the new one.
                    if (imem_req && !imem_ready) begin
                        state_nxt      = DRAIN;
                        drain_addr_nxt = pc_reg;
                    end
                end else if (imem_req && imem_ready) begin
                    push   = 1'b1;
                    pc_nxt = pc_plus4;
`ifdef FETCH_JUMP_SHORTCUT_EN
                    if (imem_rdata[31:27] == 5'b00001)
                        pc_nxt = {pc_plus4[31:28], imem_rdata[25:0], 2'b00};
`endif
                end
            end
            DRAIN: begin
                // Finish the abandoned request; its data is dropped.
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                if (redirect_valid) pc_nxt = redirect_aligned;
                if (imem_ready)     state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    assign fetch_valid = (count != 2'd0);
    assign pop         = fetch_valid & ~stall & ~redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg     <= RESET_PC;
            drain_addr <= '0;
            req_en     <= 1'b0;
            count      <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
        end else begin
            pc_reg     <= pc_nxt;
            drain_addr <= drain_addr_nxt;
            req_en     <= 1'b1;
            if (redirect_valid) begin
                count  <= '0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // Buffer storage needs no reset: it is only observed while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]   <= pc_reg;
            buf_inst[wr_ptr] <= imem_rdata;
        end
    end

    assign PC     = fetch_valid ? buf_pc[rd_ptr] + 32'd4 : 32'd0;
    assign inCode = fetch_valid ? buf_inst[rd_ptr] : 32'd0;

    // inCode is zero when empty, and opcode 0 matches no flag.
    assign op     = inCode[31:26];
    assign BEQ    = (op == 6'b000100);
    assign BNE    = (op == 6'b000101);
    assign branch = BEQ | BNE;
    assign jump   = (op == 6'b000010) | (op == 6'b000011);

    assign stall_branch = redirect_valid | (~fetch_valid & ~stall);

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] PC, inCode;
    logic        branch, jump, BEQ, BNE, fetch_valid, stall_branch;

    int tests = 0;
    int fails = 0;
    int lat = 1;   // cycles a request is visible, including the ready cycle
    int wcnt = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .PC(PC), .inCode(inCode), .branch(branch), .jump(jump),
        .BEQ(BEQ), .BNE(BNE), .fetch_valid(fetch_valid), .stall_branch(stall_branch)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h200: return 32'h1000_0003;  // BEQ
            32'h204: return 32'h0800_0040;  // J 0x100
            32'h208: return 32'h1400_0000;  // BNE
            default: return {6'b0, a[25:0]};
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign imem_ready = imem_req && (wcnt + 1 >= lat);

    always @(posedge clk) begin
        if (reset)                      wcnt <= 0;
        else if (imem_req && !imem_ready) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reset, then on the first idle cycle redirect to rpc; returns at the
    // negedge where the first request is visible.
    task automatic restart(input logic [31:0] rpc, input int l, input logic st);
        @(negedge clk);
        reset = 1'b1; redirect_valid = 1'b0; stall = 1'b0; lat = l;
        @(negedge clk);
        reset = 1'b0; redirect_valid = 1'b1; redirect_pc = rpc; stall = st;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; lat = 1;
        @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_fv", fetch_valid, 0);
        chk("rst_pc", PC, 0);
        chk("rst_incode", inCode, 0);
        chk("rst_flags", {branch, jump, BEQ, BNE}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("r_req0", imem_req, 1);
        chk("r_addr0", imem_addr, 32'h0);
        chk("r_fv0", fetch_valid, 0);
        chk("r_sb0", stall_branch, 1);
        @(negedge clk);
        chk("r_pc1", PC, 32'h4);
        chk("r_addr1", imem_addr, 32'h4);
        chk("r_sb1", stall_branch, 0);
        @(negedge clk);
        chk("r_pc2", PC, 32'h8);
        chk("r_addr2", imem_addr, 32'h8);
        @(negedge clk);
        chk("r_pc3", PC, 32'hC);
        chk("r_sb3", stall_branch, 0);
    endtask

    task automatic test_latency;
        restart(32'h10, 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("lat_addr", imem_addr, 32'h10);
            chk("lat_req", imem_req, 1);
            chk("lat_fv", fetch_valid, 0);
            chk("lat_sb", stall_branch, 1);
            @(negedge clk);
        end
        chk("lat_fv1", fetch_valid, 1);
        chk("lat_pc1", PC, 32'h14);
        chk("lat_addr1", imem_addr, 32'h14);
        @(negedge clk);
        chk("lat_fv_gap", fetch_valid, 0);
        chk("lat_sb_gap", stall_branch, 1);
        @(negedge clk);
        chk("lat_fv_gap2", fetch_valid, 0);
        @(negedge clk);
        chk("lat_fv2", fetch_valid, 1);
        chk("lat_pc2", PC, 32'h18);
    endtask

    task automatic test_stall;
        restart(32'h20, 1, 1'b1);
        @(negedge clk);
        chk("st_head0", inCode, 32'h20);
        chk("st_sb", stall_branch, 0);
        @(negedge clk);
        chk("st_req_full", imem_req, 0);
        @(negedge clk);
        chk("st_req_full2", imem_req, 0);
        chk("st_head1", inCode, 32'h20);
        @(negedge clk);
        chk("st_head2", inCode, 32'h20);
        chk("st_pc", PC, 32'h24);
        stall = 1'b0;
        @(negedge clk);
        chk("st_out1", inCode, 32'h24);
        chk("st_req_again", imem_req, 1);
        @(negedge clk);
        chk("st_out2", inCode, 32'h28);
        chk("st_pc2", PC, 32'h2C);
    endtask

    task automatic test_redirect;
        restart(32'h40, 3, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        chk("rd_sb", stall_branch, 1);
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("rd_drain_addr", imem_addr, 32'h40);
        chk("rd_drain_req", imem_req, 1);
        @(negedge clk);
        chk("rd_drain_addr2", imem_addr, 32'h40);
        chk("rd_drain_rdy", imem_ready, 1);
        @(negedge clk);
        chk("rd_new_addr", imem_addr, 32'h100);
        chk("rd_dropped", fetch_valid, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rd_fv", fetch_valid, 1);
        chk("rd_pc", PC, 32'h104);
        chk("rd_incode", inCode, 32'h100);
    endtask

    task automatic test_predecode;
        restart(32'h200, 1, 1'b0);
        @(negedge clk);
        chk("pd_beq_flags", {branch, jump, BEQ, BNE}, 4'b1010);
        chk("pd_beq_code", inCode, 32'h1000_0003);
        @(negedge clk);
        chk("pd_j_flags", {branch, jump, BEQ, BNE}, 4'b0100);
`ifdef FETCH_JUMP_SHORTCUT_EN
        chk("pd_j_next", imem_addr, 32'h100);
`else
        chk("pd_j_next", imem_addr, 32'h208);
        @(negedge clk);
        chk("pd_bne_flags", {branch, jump, BEQ, BNE}, 4'b1001);
`endif
    endtask

    task automatic test_wrap;
        restart(32'hFFFF_FFFF, 1, 1'b0);
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wr_pc", PC, 32'h0);
        chk("wr_next", imem_addr, 32'h0);
    endtask

    task automatic test_reset_drain;
        restart(32'h40, 3, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("rdn_in_drain", imem_addr, 32'h40);
        reset = 1'b1;
        @(negedge clk);
        chk("rdn_req", imem_req, 0);
        chk("rdn_fv", fetch_valid, 0);
        reset = 1'b0; lat = 1;
        @(negedge clk);
        chk("rdn_restart_req", imem_req, 1);
        chk("rdn_restart_addr", imem_addr, 32'h0);
        @(negedge clk);
        chk("rdn_pc", PC, 32'h4);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_redirect();
        test_predecode();
        test_wrap();
        test_reset_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the program counter and drives a request/ready instruction-memory port that may have wait states.
- Buffers up to 2 fetched words, predecodes branch/jump opcodes, and presents pc/instruction/flags plus a bubble strobe (stall_branch) to IF/ID.
- Accepts stall from the hazard unit and PC redirects from branch/jump resolution.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  IF/ID not accepting this cycle (hazard unit).
redirect_valid  input  1  branch taken or jump resolved downstream; flush and refetch.
redirect_pc  input  32  new fetch address; valid with redirect_valid.
imem_req  output  1  instruction-memory request.
imem_addr  output  32  word address of the request.
imem_ready  input  1  memory returns imem_rdata this cycle; transfer = imem_req & imem_ready.
imem_rdata  input  32  instruction word.
PC  output  32  head entry fetch address + 4.
inCode  output  32  head entry instruction.
branch  output  1  head opcode is BEQ or BNE.
jump  output  1  head opcode is J or JAL.
BEQ  output  1  opcode == 6'b000100.
BNE  output  1  opcode == 6'b000101.
fetch_valid  output  1  buffer non-empty.
stall_branch  output  1  bubble/flush strobe to IF/ID.

Behaviour:
- Reset (reset=1 at a rising edge):
  - pc_reg=RESET_PC, buffer count=0, state=FETCH, imem_req=0.
  - All data outputs read 0 (empty-buffer values).
  - Reset overrides every other input, including mid-transfer; any outstanding memory response is abandoned.
- State FETCH:
  - imem_req=1 when count<2, else 0.
  - imem_addr=pc_reg.
  - Once imem_req is raised, req and addr are held stable until imem_ready.
  - Zero-wait: imem_ready may be high in the same cycle as the request.
- Transfer (req&ready, no redirect):
  - Push {pc_reg, imem_rdata} into the buffer.
  - pc_reg += 4, wrapping 32'hFFFF_FFFC -> 0.
- Buffer:
  - 2-entry FIFO; head drives PC/inCode/flags.
  - Empty: PC, inCode and flags read 0.
  - Pop when fetch_valid & ~stall & ~redirect_valid.
  - Push and pop in the same cycle leave count unchanged.
  - Count never exceeds 2, because requests are issued only while count<2.
- Predecode:
  - Combinational from head inCode[31:26].
  - J = 000010, JAL = 000011.
  - All flags 0 when the buffer is empty.
- stall_branch = redirect_valid | (~fetch_valid & ~stall).
  - Clears IF/ID on an empty fetch or a flush.
  - Never asserts on an empty buffer while stall=1, so a held IF/ID entry is preserved.
- Redirect (priority over stall and transfer):
  - Flush the buffer (count=0). pc_reg=redirect_pc.
  - Request in flight, not ready this cycle -> state DRAIN.
  - Ready in the same cycle -> data discarded, remain in FETCH with the new pc.
- State DRAIN:
  - Hold imem_req=1 with the old address until imem_ready; discard the data.
  - Then -> FETCH; the request to pc_reg is issued the next cycle.
  - A further redirect during DRAIN overwrites pc_reg and stays in DRAIN.
- Latency: zero-wait memory gives a new buffered word every cycle; the first valid output appears 2 cycles after reset deassertion.
- redirect_pc[1:0] is ignored; the address is forced word-aligned.

Optional Feature:
- Macro: FETCH_JUMP_SHORTCUT_EN.
- Defined: on a transfer whose imem_rdata opcode is J or JAL, pc_reg loads {pc_reg[31:28]+carry from pc_reg+4, rdata[25:0], 2'b00} instead of +4. The entry is still pushed with jump=1.
- Undefined: pc_reg always +4; jumps are resolved only through redirect.

Test Plan:
- Reset with RESET_PC=0, zero-wait memory, stall=0:
  - imem_addr sequence 0,4,8.
  - PC outputs 4,8,12 on consecutive cycles.
  - stall_branch=1 only in the first cycle after reset.
- 3-cycle memory latency:
  - imem_addr holds 0x10 for 3 cycles.
  - fetch_valid pulses once per transfer; stall_branch=1 on empty cycles.
- stall=1 for 5 cycles:
  - count reaches 2 and imem_req drops.
  - Head stays inCode of address 0x20.
  - After release, outputs 0x20, 0x24, 0x28 in order with no loss.
- redirect_valid with redirect_pc=0x100 while a request to 0x40 is pending 2 more cycles:
  - req holds 0x40 until ready and the data is dropped.
  - Next request is 0x100; stall_branch=1 in the redirect cycle.
- imem_rdata=0x1000_0003 (BEQ):
  - branch=1, BEQ=1, BNE=0.
  - 0x0800_0040 (J) gives jump=1.
  - With FETCH_JUMP_SHORTCUT_EN, the next imem_addr is 0x100; without it, pc+4.
- Reset asserted mid-DRAIN: next cycle imem_req=0, fetch_valid=0, then fetch restarts at RESET_PC.
